// File: rtl/apb_slave_regbank.sv
// APB responder that terminates one psel line as a small register bank with wait states.
// Define APB_SLAVE_REGBANK_ERR_EN to report bad accesses on pslverr (default: pslverr tied 0).
module apb_slave_regbank #(
    parameter int                      PADDR_WIDTH  = 32,
    parameter int                      PWDATA_WIDTH = 32,
    parameter int                      PRDATA_WIDTH = 32,
    parameter int                      NUM_REGS     = 16,
    parameter int                      SLAVE_INDEX  = 0,
    parameter int                      WAIT_STATES  = 1,
    parameter logic [PRDATA_WIDTH-1:0] ID_VALUE     = 32'h0A9B_0001
) (
    input  logic                    pclock,
    input  logic                    preset,
    input  logic [PADDR_WIDTH-1:0]  paddr,
    input  logic                    prwd,
    input  logic [PWDATA_WIDTH-1:0] pwdata,
    input  logic                    penable,
    input  logic [15:0]             psel,
    output logic [PRDATA_WIDTH-1:0] prdata,
    output logic                    pready,
    output logic                    pslverr
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CPY_W = (PWDATA_WIDTH < PRDATA_WIDTH) ? PWDATA_WIDTH : PRDATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

    state_t                                r_state;
    logic [3:0]                            r_cnt;
    logic [PADDR_WIDTH-1:0]                r_addr;
    logic                                  r_wr;
    logic [PRDATA_WIDTH-1:0]               r_wdata;
    logic [NUM_REGS-1:0][PRDATA_WIDTH-1:0] r_regs;
    logic                                  r_pready;
    logic                                  r_pslverr;
    logic [PRDATA_WIDTH-1:0]               r_prdata;

    logic                    w_sel;
    logic                    w_access;
    logic                    w_unused_psel;
    logic [PADDR_WIDTH-1:0]  w_dec_addr;
    logic                    w_dec_wr;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_err;
    logic                    w_err_rpt;
    logic [PRDATA_WIDTH-1:0] w_rdata;
    logic [PRDATA_WIDTH-1:0] w_wdata_fit;

    assign w_sel         = psel[SLAVE_INDEX];
    assign w_unused_psel = &{1'b0, psel};
    assign w_access      = w_sel & penable;

    // With zero wait states the response is built from the live bus in the same edge that captures it.
    assign w_dec_addr = (r_state == S_IDLE) ? paddr : r_addr;
    assign w_dec_wr   = (r_state == S_IDLE) ? prwd  : r_wr;
    assign w_idx      = w_dec_addr[2 +: IDX_W];
    assign w_err      = (w_dec_addr[1:0] != 2'b00)
                     || ((w_dec_addr >> (IDX_W + 2)) != '0)
                     || (w_dec_wr && (w_idx == '0));

`ifdef APB_SLAVE_REGBANK_ERR_EN
    assign w_err_rpt = w_err;
`else
    assign w_err_rpt = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        if (!w_err && !w_dec_wr)
            w_rdata = (w_idx == '0) ? ID_VALUE : r_regs[w_idx];
    end

    always_comb begin
        w_wdata_fit              = '0;
        w_wdata_fit[CPY_W-1:0]   = pwdata[CPY_W-1:0];
    end

    always_ff @(posedge pclock) begin
        if (preset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wr      <= 1'b0;
            r_wdata   <= '0;
            r_regs    <= '0;
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel && !penable) begin
                        r_addr  <= paddr;
                        r_wr    <= prwd;
                        r_wdata <= w_wdata_fit;
                        r_cnt   <= 4'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            r_state   <= S_READY;
                            r_pready  <= 1'b1;
                            r_prdata  <= w_rdata;
                            r_pslverr <= w_err_rpt;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!w_access) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_state   <= S_READY;
                        r_pready  <= 1'b1;
                        r_prdata  <= w_rdata;
                        r_pslverr <= w_err_rpt;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_READY: begin
                    r_state <= S_IDLE;
                    if (w_access && r_wr && !w_err)
                        r_regs[w_idx] <= r_wdata;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pready  = r_pready;
    assign prdata  = r_prdata;
    assign pslverr = r_pslverr;
endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: two instances (psel[0] with 1 wait state, psel[1] with none)
// checked by directed vectors, corner sequences and random transfers against a register model.
module tb_apb_slave_regbank;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] paddr, pwdata;
    logic        prwd, penable;
    logic [15:0] psel;
    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b;

    int total = 0;
    int bad   = 0;
    int xbad  = 0;

    localparam logic [31:0] ID = 32'h0A9B_0001;
`ifdef APB_SLAVE_REGBANK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic [31:0] mregs [2][16];

    always #5 clk = ~clk;

    apb_slave_regbank #(.SLAVE_INDEX(0), .WAIT_STATES(1)) dut_a (
        .pclock(clk), .preset(rst), .paddr(paddr), .prwd(prwd), .pwdata(pwdata),
        .penable(penable), .psel(psel), .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a));

    apb_slave_regbank #(.SLAVE_INDEX(1), .WAIT_STATES(0)) dut_b (
        .pclock(clk), .preset(rst), .paddr(paddr), .prwd(prwd), .pwdata(pwdata),
        .penable(penable), .psel(psel), .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit m_err(input bit wr, input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'd64) || (wr && (a[5:2] == 4'd0));
    endfunction

    function automatic logic [31:0] m_read(input int s, input logic [31:0] a);
        if (m_err(1'b0, a)) return 32'h0;
        return (a[5:2] == 4'd0) ? ID : mregs[s][a[5:2]];
    endfunction

    function automatic int m_lat(input int s);
        return (s == 0) ? 2 : 1;
    endfunction

    // Called just after a rising edge; returns just after the edge that ends the pready cycle.
    task automatic xfer(input int s, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
        if (pready_a || pready_b) xbad++;
        psel = 16'h1 << s; paddr = a; prwd = wr; pwdata = d; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1; paddr = $urandom; pwdata = $urandom;
        lat = 0; rd = 32'h0; er = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if ((s == 0) ? pready_b : pready_a) xbad++;
            if ((s == 0) ? pready_a : pready_b) begin
                lat = k;
                rd  = (s == 0) ? prdata_a : prdata_b;
                er  = (s == 0) ? pslverr_a : pslverr_b;
                break;
            end
        end
        @(posedge clk); #1;
        psel = 16'h0; penable = 1'b0;
    endtask

    task automatic mxfer(input string nm, input int s, input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd, exp_rd;
        logic        er;
        int          lat;
        bit          e;
        e      = m_err(wr, a);
        exp_rd = wr ? 32'h0 : m_read(s, a);
        xfer(s, wr, a, d, rd, er, lat);
        chk({nm, "_lat"}, 32'(lat), 32'(m_lat(s)));
        chk({nm, "_rdata"}, rd, exp_rd);
        chk({nm, "_err"}, 32'(er), 32'(ERR_EN & e));
        if (wr && !e) mregs[s][a[5:2]] = d;
    endtask

    typedef struct {
        int          s;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        bit          err;
    } vec_t;

    initial begin
        vec_t        vecs [10];
        logic [31:0] rd;
        logic        er;
        int          lat;

        for (int s = 0; s < 2; s++) for (int i = 0; i < 16; i++) mregs[s][i] = 32'h0;
        rst = 1'b1; psel = 16'h0; penable = 1'b0; prwd = 1'b0; paddr = 32'h0; pwdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_pready", 32'({pready_a, pready_b}), 32'h0);
        chk("reset_prdata", prdata_a | prdata_b, 32'h0);
        chk("reset_pslverr", 32'({pslverr_a, pslverr_b}), 32'h0);
        @(posedge clk); #1;

        vecs[0] = '{0, 1'b0, 32'h00, 32'h0,        ID,           1'b0};
        vecs[1] = '{1, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[2] = '{1, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[3] = '{0, 1'b1, 32'h00, 32'h1,        32'h0,        1'b1};
        vecs[4] = '{0, 1'b0, 32'h40, 32'h0,        32'h0,        1'b1};
        vecs[5] = '{0, 1'b1, 32'h06, 32'h77,       32'h0,        1'b1};
        vecs[6] = '{0, 1'b0, 32'h00, 32'h0,        ID,           1'b0};
        vecs[7] = '{0, 1'b1, 32'h08, 32'h12345678, 32'h0,        1'b0};
        vecs[8] = '{0, 1'b0, 32'h08, 32'h0,        32'h12345678, 1'b0};
        vecs[9] = '{1, 1'b0, 32'h3C, 32'h0,        32'h0,        1'b0};
        for (int i = 0; i < 10; i++) begin
            xfer(vecs[i].s, vecs[i].wr, vecs[i].a, vecs[i].d, rd, er, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(m_lat(vecs[i].s)));
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(ERR_EN & vecs[i].err));
            if (vecs[i].wr && !vecs[i].err) mregs[vecs[i].s][vecs[i].a[5:2]] = vecs[i].d;
        end

        // Abort: psel drops during the wait cycle of a write.
        psel = 16'h1; prwd = 1'b1; paddr = 32'h4; pwdata = 32'h55; penable = 1'b0;
        @(posedge clk); #1;
        psel = 16'h0;
        lat = 0;
        repeat (3) begin @(negedge clk); if (pready_a) lat++; end
        chk("abort_no_pready", 32'(lat), 32'h0);
        @(posedge clk); #1;
        mxfer("abort_readback", 0, 1'b0, 32'h4, 32'h0);

        // Only a foreign select line: neither instance may respond or change state.
        psel = 16'h8; prwd = 1'b1; paddr = 32'h8; pwdata = 32'hAAAA5555; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0;
        repeat (4) begin @(negedge clk); if (pready_a || pready_b) lat++; end
        chk("foreign_sel_pready", 32'(lat), 32'h0);
        @(posedge clk); #1;
        psel = 16'h0; penable = 1'b0;
        mxfer("foreign_rd_a", 0, 1'b0, 32'h8, 32'h0);
        mxfer("foreign_rd_b", 1, 1'b0, 32'h8, 32'h0);

        // Reset in the wait cycle of a write to a previously written register.
        mxfer("rst_pre_wr", 0, 1'b1, 32'hC, 32'h12);
        mxfer("rst_pre_rd", 0, 1'b0, 32'hC, 32'h0);
        psel = 16'h1; prwd = 1'b1; paddr = 32'hC; pwdata = 32'h99; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; psel = 16'h0; penable = 1'b0;
        for (int s = 0; s < 2; s++) for (int i = 0; i < 16; i++) mregs[s][i] = 32'h0;
        @(negedge clk);
        chk("midrst_pready", 32'(pready_a), 32'h0);
        chk("midrst_prdata", prdata_a, 32'h0);
        chk("midrst_pslverr", 32'(pslverr_a), 32'h0);
        @(posedge clk); #1;
        mxfer("midrst_rd_c", 0, 1'b0, 32'hC, 32'h0);
        mxfer("midrst_rd_b8", 1, 1'b0, 32'h8, 32'h0);

        for (int n = 0; n < 150; n++) begin
            int          s;
            bit          wr;
            logic [31:0] a;
            s  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       a = $urandom & 32'hFF;
                1:       a = 32'h40 + 32'($urandom_range(0, 63));
                default: a = 32'($urandom_range(0, 15)) << 2;
            endcase
            mxfer($sformatf("rnd%0d", n), s, wr, a, $urandom);
        end

        chk("cross_or_stuck_pready", 32'(xbad), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
